// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU definitions: entry-stage encoding, opcode width and opcodes
package alu_pkg;

  localparam int OP_WIDTH = 3;

  typedef enum logic [1:0] {
    GET_A  = 2'd0,
    GET_B  = 2'd1,
    GET_OP = 2'd2,
    ISSUE  = 2'd3
  } state_t;

  localparam logic [OP_WIDTH-1:0] OP_ADD = 3'd0;
  localparam logic [OP_WIDTH-1:0] OP_SUB = 3'd1;
  localparam logic [OP_WIDTH-1:0] OP_AND = 3'd2;
  localparam logic [OP_WIDTH-1:0] OP_OR  = 3'd3;
  localparam logic [OP_WIDTH-1:0] OP_XOR = 3'd4;
  localparam logic [OP_WIDTH-1:0] OP_NOT = 3'd5;
  localparam logic [OP_WIDTH-1:0] OP_SHL = 3'd6;
  localparam logic [OP_WIDTH-1:0] OP_SHR = 3'd7;

endpackage

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - 2-FF synchronizer, stability counter and one-cycle press pulse
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic          sync1_q, sync2_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      press   <= 1'b0;
      if (sync2_q != level_q) begin
        if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          level_q <= sync2_q;
          cnt_q   <= '0;
          // Only the debounced falling edge is a press; release is silent.
          press   <= ~sync2_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - captures A, B and opcode from switches and issues them to the ALU
// Define OPERAND_SIGN_EXT_EN to sign-extend switch operands instead of zero-extending.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int WORD_SIZE       = 16,
  parameter int SW_WIDTH        = 10,
  parameter int OP_WIDTH        = alu_pkg::OP_WIDTH,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                 CLOCK_50,
  input  logic                 rst_n,
  input  logic [SW_WIDTH-1:0]  sw,
  input  logic                 key_enter_n,
  input  logic                 key_clear_n,
  output logic [WORD_SIZE-1:0] a_o,
  output logic [WORD_SIZE-1:0] b_o,
  output logic [OP_WIDTH-1:0]  op_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [1:0]           stage_o
);

  logic [SW_WIDTH-1:0]  sw_meta_q, sw_sync;
  logic                 enter_pulse, clear_pulse;
  logic [WORD_SIZE-1:0] sw_ext;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] a_d, b_d;
  logic [OP_WIDTH-1:0]  op_d;
  logic                 valid_d;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk   (CLOCK_50),
    .rst_n (rst_n),
    .key_n (key_enter_n),
    .press (enter_pulse)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk   (CLOCK_50),
    .rst_n (rst_n),
    .key_n (key_clear_n),
    .press (clear_pulse)
  );

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q <= '0;
      sw_sync   <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync   <= sw_meta_q;
    end
  end

  // The size cast widens or truncates to WORD_SIZE in either build.
`ifdef OPERAND_SIGN_EXT_EN
  assign sw_ext = WORD_SIZE'($signed(sw_sync));
`else
  assign sw_ext = WORD_SIZE'(sw_sync);
`endif

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GET_A;
      a_o     <= '0;
      b_o     <= '0;
      op_o    <= '0;
      valid_o <= 1'b0;
    end else begin
      state_q <= state_d;
      a_o     <= a_d;
      b_o     <= b_d;
      op_o    <= op_d;
      valid_o <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_o;
    b_d     = b_o;
    op_d    = op_o;
    valid_d = valid_o;
    case (state_q)
      // Buttons are ignored here so the triple stays stable for the handshake.
      ISSUE: begin
        if (ready_i) begin
          valid_d = 1'b0;
          state_d = GET_A;
        end
      end
      default: begin
        if (clear_pulse) begin
          state_d = GET_A;
          a_d     = '0;
          b_d     = '0;
          op_d    = '0;
        end else if (enter_pulse) begin
          case (state_q)
            GET_A: begin
              a_d     = sw_ext;
              state_d = GET_B;
            end
            GET_B: begin
              b_d     = sw_ext;
              state_d = GET_OP;
            end
            GET_OP: begin
              op_d    = sw_sync[OP_WIDTH-1:0];
              valid_d = 1'b1;
              state_d = ISSUE;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  assign stage_o = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// tb/tb_alu_operand_loader.sv - directed self-checking bench for alu_operand_loader
module tb_alu_operand_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  sw = '0;
  logic        key_enter_n = 1'b1;
  logic        key_clear_n = 1'b1;
  logic [15:0] a_o, b_o;
  logic [2:0]  op_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [1:0]  stage_o;

  int total = 0;
  int bad = 0;

  alu_operand_loader #(
    .WORD_SIZE       (16),
    .SW_WIDTH        (10),
    .OP_WIDTH        (3),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .CLOCK_50    (clk),
    .rst_n       (rst_n),
    .sw          (sw),
    .key_enter_n (key_enter_n),
    .key_clear_n (key_clear_n),
    .a_o         (a_o),
    .b_o         (b_o),
    .op_o        (op_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .stage_o     (stage_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_enter();
    key_enter_n = 1'b0;
    cycles(10);
    key_enter_n = 1'b1;
    cycles(10);
  endtask

  task automatic press_clear();
    key_clear_n = 1'b0;
    cycles(10);
    key_clear_n = 1'b1;
    cycles(10);
  endtask

  int          changes;
  int          vcount;
  logic [15:0] cap_a, cap_b;
  logic [2:0]  cap_op;

  initial begin
    // 1: reset then idle
    cycles(3);
    rst_n = 1'b1;
    cycles(1);
    chk("rst_a", a_o, 0);
    chk("rst_b", b_o, 0);
    chk("rst_op", op_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_stage", stage_o, 0);
    changes = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_o !== 16'h0 || b_o !== 16'h0 || op_o !== 3'h0 || valid_o !== 1'b0 || stage_o !== 2'd0)
        changes++;
    end
    chk("idle_changes", changes, 0);

    // 2: full entry with ready held high
    ready_i = 1'b1;
    sw = 10'h005;
    press_enter();
    chk("s2_stage_b", stage_o, 1);
    chk("s2_a", a_o, 16'h0005);
    sw = 10'h003;
    press_enter();
    chk("s2_stage_op", stage_o, 2);
    chk("s2_b", b_o, 16'h0003);
    sw = 10'h002;
    key_enter_n = 1'b0;
    vcount = 0;
    cap_a = '0;
    cap_b = '0;
    cap_op = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid_o === 1'b1) begin
        vcount++;
        cap_a = a_o;
        cap_b = b_o;
        cap_op = op_o;
      end
    end
    key_enter_n = 1'b1;
    cycles(10);
    chk("s2_valid_cycles", vcount, 1);
    chk("s2_cap_a", cap_a, 16'h0005);
    chk("s2_cap_b", cap_b, 16'h0003);
    chk("s2_cap_op", cap_op, 3'b010);
    chk("s2_stage_end", stage_o, 0);

    // 3: backpressure, clear and enter ignored in ISSUE
    ready_i = 1'b0;
    sw = 10'h011;
    press_enter();
    sw = 10'h022;
    press_enter();
    sw = 10'h006;
    press_enter();
    chk("s3_valid", valid_o, 1);
    chk("s3_stage", stage_o, 3);
    press_clear();
    press_enter();
    cycles(10);
    chk("s3_hold_valid", valid_o, 1);
    chk("s3_hold_stage", stage_o, 3);
    chk("s3_hold_a", a_o, 16'h0011);
    chk("s3_hold_b", b_o, 16'h0022);
    chk("s3_hold_op", op_o, 3'd6);
    ready_i = 1'b1;
    @(negedge clk);
    chk("s3_drop_valid", valid_o, 0);
    chk("s3_drop_stage", stage_o, 0);
    chk("s3_keep_a", a_o, 16'h0011);
    ready_i = 1'b0;
    cycles(2);

    // 4: bounce rejection then one clean press
    sw = 10'h0AA;
    cycles(3);
    for (int i = 0; i < 5; i++) begin
      key_enter_n = 1'b0;
      cycles(2);
      key_enter_n = 1'b1;
      cycles(2);
    end
    chk("s4_bounce_stage", stage_o, 0);
    key_enter_n = 1'b0;
    cycles(8);
    chk("s4_advance_stage", stage_o, 1);
    key_enter_n = 1'b1;
    cycles(10);
    chk("s4_single_advance", stage_o, 1);
    chk("s4_a", a_o, 16'h00AA);

    // 5: coincident enter and clear in GET_B, clear wins
    sw = 10'h055;
    key_enter_n = 1'b0;
    key_clear_n = 1'b0;
    cycles(10);
    key_enter_n = 1'b1;
    key_clear_n = 1'b1;
    cycles(10);
    chk("s5_stage", stage_o, 0);
    chk("s5_a", a_o, 0);
    chk("s5_b", b_o, 0);

    // 6: operand extension of an all-ones switch word
    sw = 10'h3FF;
    press_enter();
`ifdef OPERAND_SIGN_EXT_EN
    chk("s6_a_ext", a_o, 16'hFFFF);
`else
    chk("s6_a_ext", a_o, 16'h03FF);
`endif
    chk("s6_stage", stage_o, 1);

    // reset mid-entry returns everything to reset values
    rst_n = 1'b0;
    #1;
    chk("rst_mid_stage", stage_o, 0);
    chk("rst_mid_a", a_o, 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
    chk("rst_mid_valid", valid_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
